// File: rtl/operand_issue_stage.sv
// operand_issue_stage: RV32I decode/operand-issue stage with the 32x32 register file
// and a valid/ready ID/EX pipeline register.
`default_nettype none

module operand_issue_stage #(
  parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] instr,
  input  logic        wb_en,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] a1,
  output logic [31:0] a2,
  output logic [31:0] imm_ext,
  output logic        alu_scr2,
  output logic [4:0]  rd,
  output logic        reg_write,
  output logic        illegal,
  output logic [31:0] out_instr
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  logic [31:0] rf_q [32];

  logic        out_valid_q;
  logic [31:0] a1_q, a2_q, imm_q, instr_q;
  logic        alu_scr2_q, reg_write_q, illegal_q;
  logic [4:0]  rd_q;

  logic [4:0]  rs1, rs2;
  logic [31:0] rs1_val, rs2_val;
  logic [31:0] imm_d;
  logic        alu_scr2_d, reg_write_d, illegal_d;
  logic        accept, drain, wb_hit;

  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];
  assign wb_hit = wb_en & (wb_rd != 5'd0);

  assign in_ready = ~out_valid_q | out_ready | flush;
  assign accept   = in_valid & in_ready & ~flush;
  assign drain    = out_valid_q & out_ready;

  // Write-through bypass so an operand written this cycle is not issued stale.
  always_comb begin
    rs1_val = 32'd0;
    rs2_val = 32'd0;
    if (rs1 != 5'd0) rs1_val = (wb_hit && wb_rd == rs1) ? wb_data : rf_q[rs1];
    if (rs2 != 5'd0) rs2_val = (wb_hit && wb_rd == rs2) ? wb_data : rf_q[rs2];
  end

  always_comb begin
    imm_d       = 32'd0;
    alu_scr2_d  = 1'b0;
    reg_write_d = 1'b0;
    illegal_d   = 1'b0;
    unique case (instr[6:0])
      OP_R: begin
        reg_write_d = 1'b1;
      end
      OP_IMM, OP_LOAD, OP_JALR: begin
        imm_d       = {{20{instr[31]}}, instr[31:20]};
        alu_scr2_d  = 1'b1;
        reg_write_d = 1'b1;
      end
      OP_STORE: begin
        imm_d      = {{20{instr[31]}}, instr[31:25], instr[11:7]};
        alu_scr2_d = 1'b1;
      end
      OP_BRANCH: begin
        imm_d = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      end
      OP_LUI, OP_AUIPC: begin
        imm_d       = {instr[31:12], 12'd0};
        alu_scr2_d  = 1'b1;
        reg_write_d = 1'b1;
      end
      OP_JAL: begin
        imm_d       = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
        alu_scr2_d  = 1'b1;
        reg_write_d = 1'b1;
      end
      default: begin
        illegal_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) rf_q[i] <= 32'd0;
    end else if (wb_hit) begin
      rf_q[wb_rd] <= wb_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      out_valid_q <= 1'b0;
      a1_q        <= 32'd0;
      a2_q        <= 32'd0;
      imm_q       <= 32'd0;
      alu_scr2_q  <= 1'b0;
      rd_q        <= 5'd0;
      reg_write_q <= 1'b0;
      illegal_q   <= 1'b0;
      instr_q     <= NOP_INSTR;
    end else if (accept) begin
      out_valid_q <= 1'b1;
      a1_q        <= rs1_val;
      a2_q        <= rs2_val;
      imm_q       <= imm_d;
      alu_scr2_q  <= alu_scr2_d;
      rd_q        <= instr[11:7];
      reg_write_q <= reg_write_d;
      illegal_q   <= illegal_d;
      instr_q     <= instr;
    end else if (drain) begin
      out_valid_q <= 1'b0;
    end else if (out_valid_q) begin
      // Held entry: keep its operands coherent with writebacks that land while stalled.
      if (wb_hit && wb_rd == instr_q[19:15]) a1_q <= wb_data;
      if (wb_hit && wb_rd == instr_q[24:20]) a2_q <= wb_data;
    end
  end

  assign out_valid = out_valid_q;
  assign a1        = a1_q;
  assign a2        = a2_q;
  assign imm_ext   = imm_q;
  assign alu_scr2  = alu_scr2_q;
  assign rd        = rd_q;
  assign reg_write = reg_write_q;
  assign illegal   = illegal_q;
  assign out_instr = instr_q;

endmodule

`default_nettype wire

// File: tb/tb_operand_issue_stage.sv
// tb_operand_issue_stage: directed self-checking bench for operand_issue_stage.
`default_nettype none

module tb_operand_issue_stage;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, wb_en, flush, out_valid, out_ready;
  logic        alu_scr2, reg_write, illegal;
  logic [31:0] instr, wb_data, a1, a2, imm_ext, out_instr;
  logic [4:0]  wb_rd, rd;

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  operand_issue_stage #(.NOP_INSTR(32'h00000013)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
    .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .a1(a1), .a2(a2), .imm_ext(imm_ext),
    .alu_scr2(alu_scr2), .rd(rd), .reg_write(reg_write), .illegal(illegal),
    .out_instr(out_instr)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] w);
    in_valid = 1'b1;
    instr    = w;
    step();
    in_valid = 1'b0;
  endtask

  task automatic wb(input logic [4:0] r, input logic [31:0] d);
    wb_en = 1'b1; wb_rd = r; wb_data = d;
    step();
    wb_en = 1'b0;
  endtask

  task automatic chk_entry(input string tag, input logic [31:0] e_a1, input logic [31:0] e_imm,
                           input logic e_src2, input logic [4:0] e_rd, input logic e_rw,
                           input logic e_ill);
    chk({tag, ".valid"}, {31'd0, out_valid}, 32'd1);
    chk({tag, ".a1"},    a1, e_a1);
    chk({tag, ".imm"},   imm_ext, e_imm);
    chk({tag, ".src2"},  {31'd0, alu_scr2}, {31'd0, e_src2});
    chk({tag, ".rd"},    {27'd0, rd}, {27'd0, e_rd});
    chk({tag, ".rw"},    {31'd0, reg_write}, {31'd0, e_rw});
    chk({tag, ".ill"},   {31'd0, illegal}, {31'd0, e_ill});
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; instr = 32'd0; flush = 1'b0; out_ready = 1'b1;
    wb_en = 1'b1; wb_rd = 5'd3; wb_data = 32'hAAAA5555;
    step(); step();
    chk("rst.valid", {31'd0, out_valid}, 32'd0);
    chk("rst.a1", a1, 32'd0);
    chk("rst.a2", a2, 32'd0);
    chk("rst.imm", imm_ext, 32'd0);
    chk("rst.ctl", {26'd0, alu_scr2, reg_write, illegal, 3'd0}, 32'd0);
    chk("rst.rd", {27'd0, rd}, 32'd0);
    chk("rst.instr", out_instr, 32'h00000013);
    rst = 1'b0; wb_en = 1'b0;

    // addi x1,x3,0: x3 must still read 0 after the reset-time write attempt
    issue(32'h00018093);
    chk_entry("x3", 32'd0, 32'd0, 1'b1, 5'd1, 1'b1, 1'b0);
    step();
    chk("drain.valid", {31'd0, out_valid}, 32'd0);

    wb(5'd5, 32'd2);
    issue(32'h00428313);
    chk_entry("addi", 32'd2, 32'd4, 1'b1, 5'd6, 1'b1, 1'b0);
    chk("addi.instr", out_instr, 32'h00428313);

    wb(5'd6, 32'd4);
    issue(32'h006283B3);
    chk_entry("add", 32'd2, 32'd0, 1'b0, 5'd7, 1'b1, 1'b0);
    chk("add.a2", a2, 32'd4);

    issue(32'hFE512E23);
    chk_entry("sw", 32'd0, 32'hFFFFFFFC, 1'b1, 5'd28, 1'b0, 1'b0);
    chk("sw.a2", a2, 32'd2);

    // back-to-back issues of other immediate formats
    in_valid = 1'b1; instr = 32'h123452B7; step();
    chk_entry("lui", 32'd0, 32'h12345000, 1'b1, 5'd5, 1'b1, 1'b0);
    instr = 32'hFE000CE3; step();
    chk_entry("beq", 32'd0, 32'hFFFFFFF8, 1'b0, 5'd25, 1'b0, 1'b0);
    instr = 32'h0080006F; step();
    chk_entry("jal", 32'd0, 32'd8, 1'b1, 5'd0, 1'b1, 1'b0);
    in_valid = 1'b0;

    // bypass: writeback x9 in the same cycle as the accept that reads it
    wb_en = 1'b1; wb_rd = 5'd9; wb_data = 32'hDEADBEEF;
    issue(32'h00048513);
    wb_en = 1'b0;
    chk_entry("byp", 32'hDEADBEEF, 32'd0, 1'b1, 5'd10, 1'b1, 1'b0);

    out_ready = 1'b0;
    #1;
    chk("stall.in_ready", {31'd0, in_ready}, 32'd0);
    wb_en = 1'b1; wb_rd = 5'd9; wb_data = 32'h12345678;
    issue(32'h00428313);
    wb_en = 1'b0;
    chk("stall.a1", a1, 32'h12345678);
    chk("stall.valid", {31'd0, out_valid}, 32'd1);
    chk("stall.instr", out_instr, 32'h00048513);
    chk("stall.in_ready2", {31'd0, in_ready}, 32'd0);
    out_ready = 1'b1;
    step();
    chk("release.valid", {31'd0, out_valid}, 32'd0);

    wb(5'd0, 32'd5);
    issue(32'hFFF00093);
    chk_entry("x0", 32'd0, 32'hFFFFFFFF, 1'b1, 5'd1, 1'b1, 1'b0);

    issue(32'h0000007F);
    chk_entry("ill", 32'd0, 32'd0, 1'b0, 5'd0, 1'b0, 1'b1);

    // flush while stalled: the presented instruction is consumed and dropped
    out_ready = 1'b0; flush = 1'b1; in_valid = 1'b1; instr = 32'h00428313;
    #1;
    chk("flush.in_ready", {31'd0, in_ready}, 32'd1);
    step();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush.valid", {31'd0, out_valid}, 32'd0);
    chk("flush.instr", out_instr, 32'h00000013);
    chk("flush.a1", a1, 32'd0);
    chk("flush.ill", {31'd0, illegal}, 32'd0);
    step();
    chk("flush.valid2", {31'd0, out_valid}, 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/operand_issue_stage.md
Name: operand_issue_stage

Overview:
- Decode/operand-issue stage of the RV32I core; feeds the ALU source-2 select mux.
- Owns the 32x32 register file. Each accepted instruction is decoded into a sign-extended immediate, the ALU source-2 select and control bits.
- Reads rs1/rs2 and registers everything into the ID/EX pipeline register behind a valid/ready handshake.

Parameters:
- NOP_INSTR, 32'h00000013, instruction value loaded into the output instr field on reset/flush (addi x0,x0,0).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous reset, active-high.
- in_valid  input  1  instr is valid.
- in_ready  output  1  stage can accept instr this cycle.
- instr  input  32  RV32I instruction word.
- wb_en  input  1  register-file write enable.
- wb_rd  input  5  write register index.
- wb_data  input  32  write data.
- flush  input  1  discard the held entry and any entry presented this cycle.
- out_valid  output  1  ID/EX entry valid.
- out_ready  input  1  downstream accepts the entry.
- a1  output  32  rs1 value.
- a2  output  32  rs2 value.
- imm_ext  output  32  sign-extended immediate.
- alu_scr2  output  1  1 = ALU source 2 is imm_ext, 0 = a2.
- rd  output  5  destination index.
- reg_write  output  1  instruction writes rd.
- illegal  output  1  unknown opcode.
- out_instr  output  32  registered instruction word.

Behaviour:
- Reset: synchronous, active-high, sampled on rising clk.
  - out_valid, a1, a2, imm_ext, alu_scr2, rd, reg_write and illegal are 0; out_instr = NOP_INSTR.
  - All 32 registers are cleared to 0.
  - rst has priority over flush, wb and the handshake; reset mid-transfer drops the entry.
- Handshake and latency:
  - in_ready = ~out_valid | out_ready | flush (combinational).
  - Accept = in_valid & in_ready & ~flush. On accept, outputs load next edge (latency 1) and out_valid = 1.
  - Downstream handshake completes when out_valid & out_ready. If no new accept that cycle, out_valid goes to 0.
  - Stall (out_valid & ~out_ready): all outputs hold, except the in-place writeback update below.
- Flush: out_valid = 0 next edge. The instruction presented during the flush cycle is consumed (in_ready = 1) and discarded. Data fields return to their reset values.
- Register file:
  - Write on the edge when wb_en = 1 and wb_rd != 0.
  - Writes to x0 are ignored; reads of x0 always return 0.
  - Read is combinational with write-through bypass: if wb_en & wb_rd == rs & rs != 0, the read returns wb_data in the same cycle.
- Stale-operand fix: during a stall, a writeback whose wb_rd (nonzero) matches the held entry's rs1/rs2 field updates a1/a2 at the same edge.
- Decode by opcode (instr[6:0]):
  - 0110011 R: imm = 0, alu_scr2 = 0, reg_write = 1.
  - 0010011 OP-IMM, 0000011 LOAD, 1100111 JALR: I-immediate, alu_scr2 = 1, reg_write = 1.
  - 0100011 STORE: S-immediate, alu_scr2 = 1, reg_write = 0.
  - 1100011 BRANCH: B-immediate (bit0 = 0), alu_scr2 = 0, reg_write = 0.
  - 0110111 LUI, 0010111 AUIPC: U-immediate (instr[31:12] << 12), alu_scr2 = 1, reg_write = 1.
  - 1101111 JAL: J-immediate (bit0 = 0), alu_scr2 = 1, reg_write = 1.
  - Any other opcode: illegal = 1, imm = 0, alu_scr2 = 0, reg_write = 0. The entry still issues with out_valid = 1.
- Immediate sign extension: all sign bits come from instr[31].
- rd = instr[11:7] always. For instructions with reg_write = 0, rd is don't-care but is still driven.

Test Plan:
- Reset: assert rst 2 cycles with wb_en = 1, wb_rd = 3 -> out_valid = 0, all outputs 0, out_instr = 0x00000013; x3 reads 0 afterwards.
- I-type: write x5 = 2, then issue 0x00428313 (addi x6,x5,4) with out_ready = 1 -> next cycle out_valid = 1, a1 = 2, imm_ext = 4, alu_scr2 = 1, rd = 6, reg_write = 1.
- R-type and store:
  - With x5 = 2 and x6 = 4, issue 0x006283B3 (add x7,x5,x6) -> a1 = 2, a2 = 4, imm_ext = 0, alu_scr2 = 0.
  - Issue 0xFE512E23 (sw x5,-4(x2)) -> imm_ext = 0xFFFFFFFC, alu_scr2 = 1, reg_write = 0.
- Bypass and stall update:
  - wb x9 = 0xDEADBEEF in the same cycle an instruction reading rs1 = x9 is accepted -> a1 = 0xDEADBEEF.
  - Hold out_ready = 0 and write x9 = 0x12345678 -> a1 becomes 0x12345678, out_valid stays 1, in_ready = 0.
- x0 and sign extension: wb x0 = 5, then issue 0xFFF00093 (addi x1,x0,-1) -> a1 = 0, imm_ext = 0xFFFFFFFF.
- Flush and illegal:
  - Issue 0x0000007F -> illegal = 1, reg_write = 0.
  - With out_ready = 0, assert flush while presenting 0x00428313 -> next cycle out_valid = 0, and nothing issues for that instruction.
